// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one synchronous 32-bit instruction RAM between the CPU
// fetch port (read-only, fixed priority) and a host/loader port (read/write).
// A wait-aging counter lets a waiting host win a contended cycle after
// MAX_WAIT cycles, and host_lock gives the host exclusive back-to-back access.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   cpu_req/cpu_addr              CPU read request and word address
//   cpu_gnt                       combinational accept for the CPU
//   cpu_rvalid/cpu_rdata          registered read response, 1 cycle after grant
//   host_req/host_we/host_lock    host request, write enable, exclusive request
//   host_addr/host_wdata          host word address and write data
//   host_gnt                      combinational accept for the host
//   host_rvalid/host_rdata        registered read response (reads only)
//   locked                        registered, arbiter is in the LOCKED state
//   err_oob                       registered pulse, last granted address >= RAM_SIZE
module imem_arbiter #(
    parameter int unsigned RAM_SIZE = 8,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [7:0]  cpu_addr,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic        host_lock,
    input  logic [7:0]  host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    output logic        locked,
    output logic        err_oob
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned IDX_W  = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

    // One extra bit so RAM_SIZE == 256 still compares correctly
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(RAM_SIZE);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [DATA_W-1:0]   mem [RAM_SIZE];

    logic                cpu_in_range;
    logic                host_in_range;
    logic [DATA_W-1:0]   cpu_word;
    logic [DATA_W-1:0]   host_word;

    // Address decode and read muxes; out-of-range reads return zero
    always_comb begin
        cpu_in_range  = ({1'b0, cpu_addr} < ADDR_LIMIT);
        host_in_range = ({1'b0, host_addr} < ADDR_LIMIT);
        cpu_word      = '0;
        host_word     = '0;
        if (cpu_in_range) begin
            cpu_word = mem[cpu_addr[IDX_W-1:0]];
        end
        if (host_in_range) begin
            host_word = mem[host_addr[IDX_W-1:0]];
        end
    end

    // Grant selection and next state
    always_comb begin
        state_d  = state_q;
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (!reset) begin
            if (state_q == ST_LOCKED && host_lock) begin
                host_gnt = host_req;
            end else begin
                // Host only beats a requesting CPU once it has aged out
                host_gnt = host_req && (!cpu_req || wait_cnt == WAIT_LIMIT);
                cpu_gnt  = cpu_req && !host_gnt;
            end
            case (state_q)
                ST_ARB: begin
                    if (host_gnt && host_lock) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!host_lock) begin
                        state_d = ST_ARB;
                    end
                end
                default: state_d = ST_ARB;
            endcase
        end
    end

    // State, aging counter and registered responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ARB;
            locked      <= 1'b0;
            wait_cnt    <= '0;
            cpu_rvalid  <= 1'b0;
            cpu_rdata   <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            err_oob     <= 1'b0;
        end else begin
            state_q <= state_d;
            locked  <= (state_d == ST_LOCKED);

            if (!host_req || host_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            cpu_rvalid <= cpu_gnt;
            if (cpu_gnt) begin
                cpu_rdata <= cpu_word;
            end

            host_rvalid <= host_gnt && !host_we;
            if (host_gnt && !host_we) begin
                host_rdata <= host_word;
            end

            err_oob <= (cpu_gnt && !cpu_in_range) || (host_gnt && !host_in_range);
        end
    end

    // RAM array; contents survive reset, out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (host_gnt && host_we && host_in_range) begin
            mem[host_addr[IDX_W-1:0]] <= host_wdata;
        end
    end

endmodule
